// File: rtl/cond_flag_evaluator.sv
// Condition-code evaluator: holds the {C,Z,N,V} status register and answers
// ARM-style condition queries with a registered pass/fail over valid/ready.
module cond_flag_evaluator #(
  parameter int TAG_W     = 4,
  parameter int FWD_FLAGS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       flags_in,
  input  logic             flags_we,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cond,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_pass,
  output logic             rsp_undef,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [3:0]       status,
  output logic [CNT_W-1:0] eval_count
);

  localparam bit FWD = (FWD_FLAGS != 0);

  logic       accept;
  logic [3:0] fsel;
  logic       flag_c, flag_z, flag_n, flag_v;
  logic       cond_pass;
  logic       cond_undef;

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  // Same-cycle flag writes bypass the register only when forwarding is enabled.
  assign fsel   = (FWD && flags_we) ? flags_in : status;
  assign flag_v = fsel[0];
  assign flag_n = fsel[1];
  assign flag_z = fsel[2];
  assign flag_c = fsel[3];

  always_comb begin
    cond_pass  = 1'b0;
    cond_undef = 1'b0;
    case (req_cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = !flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = !flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = !flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = !flag_v;
      4'h8: cond_pass = flag_c && !flag_z;
      4'h9: cond_pass = !flag_c || flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = !flag_z && (flag_n == flag_v);
      4'hD: cond_pass = flag_z || (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: begin
        cond_pass  = 1'b0;
        cond_undef = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      status <= 4'h0;
    end else if (flags_we) begin
      status <= flags_in;
    end
  end

  // Response fields only load on accept, so a stalled result stays frozen.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_pass  <= 1'b0;
      rsp_undef <= 1'b0;
      rsp_tag   <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_pass  <= cond_pass;
      rsp_undef <= cond_undef;
      rsp_tag   <= req_tag;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      eval_count <= '0;
    end else if (accept && (eval_count != {CNT_W{1'b1}})) begin
      eval_count <= eval_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cond_flag_evaluator.sv
// Scoreboard bench: a forwarding/16-bit-counter instance and a non-forwarding
// 2-bit-counter instance share stimulus and are checked against a local model.
module tb_cond_flag_evaluator;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] flags_in;
  logic       flags_we;
  logic       req_valid;
  logic [3:0] req_cond;
  logic [3:0] req_tag;
  logic       rsp_ready;

  logic        req_ready_a, rsp_valid_a, rsp_pass_a, rsp_undef_a;
  logic [3:0]  rsp_tag_a, status_a;
  logic [15:0] eval_count_a;
  logic        req_ready_b, rsp_valid_b, rsp_pass_b, rsp_undef_b;
  logic [3:0]  rsp_tag_b, status_b;
  logic [1:0]  eval_count_b;

  typedef struct {
    logic       pass_a;
    logic       pass_b;
    logic       undef;
    logic [3:0] tag;
  } exp_t;

  exp_t        sb[$];
  logic [3:0]  m_status;
  logic [15:0] m_cnt_a;
  logic [1:0]  m_cnt_b;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  cond_flag_evaluator #(.TAG_W(4), .FWD_FLAGS(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .flags_in(flags_in), .flags_we(flags_we),
    .req_valid(req_valid), .req_ready(req_ready_a), .req_cond(req_cond),
    .req_tag(req_tag), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_pass(rsp_pass_a), .rsp_undef(rsp_undef_a), .rsp_tag(rsp_tag_a),
    .status(status_a), .eval_count(eval_count_a)
  );

  cond_flag_evaluator #(.TAG_W(4), .FWD_FLAGS(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .flags_in(flags_in), .flags_we(flags_we),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_cond(req_cond),
    .req_tag(req_tag), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_pass(rsp_pass_b), .rsp_undef(rsp_undef_b), .rsp_tag(rsp_tag_b),
    .status(status_b), .eval_count(eval_count_b)
  );

  // Odd codes are the negation of the even code before them, except E/F.
  function automatic logic modelPass(input logic [3:0] cond, input logic [3:0] f);
    logic c, z, n, v, base;
    c = f[3]; z = f[2]; n = f[1]; v = f[0];
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = ~(n ^ v);
      3'd6: base = ~z & ~(n ^ v);
      default: base = 1'b1;
    endcase
    if (cond == 4'hE) return 1'b1;
    if (cond == 4'hF) return 1'b0;
    return cond[0] ? ~base : base;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset_n = 1'b0; flags_we = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    flags_in = 4'h0; req_cond = 4'h0; req_tag = 4'h0;
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    m_status = 4'h0; m_cnt_a = '0; m_cnt_b = '0;
    #1;
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    checkOutput("rst_rsp_valid_b", {31'd0, rsp_valid_b}, 32'd0);
    checkOutput("rst_rsp_pass", {31'd0, rsp_pass_a}, 32'd0);
    checkOutput("rst_rsp_undef", {31'd0, rsp_undef_a}, 32'd0);
    checkOutput("rst_rsp_tag", {28'd0, rsp_tag_a}, 32'd0);
    checkOutput("rst_status", {28'd0, status_a}, 32'd0);
    checkOutput("rst_count_a", {16'd0, eval_count_a}, 32'd0);
    checkOutput("rst_count_b", {30'd0, eval_count_b}, 32'd0);
    checkOutput("rst_req_ready", {31'd0, req_ready_a}, 32'd1);
  endtask

  // One clock of stimulus: checks the outputs visible this cycle, then
  // advances the model as the DUT will on the coming rising edge.
  task automatic applyStimulus(input logic we, input logic [3:0] fl, input logic v,
                               input logic [3:0] cond, input logic [3:0] tag, input logic rr);
    logic exp_valid;
    exp_t e;
    @(negedge clk);
    flags_we = we; flags_in = fl; req_valid = v; req_cond = cond; req_tag = tag; rsp_ready = rr;
    #1;
    exp_valid = (sb.size() != 0);
    checkOutput("rsp_valid_a", {31'd0, rsp_valid_a}, {31'd0, exp_valid});
    checkOutput("rsp_valid_b", {31'd0, rsp_valid_b}, {31'd0, exp_valid});
    checkOutput("req_ready_a", {31'd0, req_ready_a}, {31'd0, (!exp_valid || rr)});
    checkOutput("req_ready_b", {31'd0, req_ready_b}, {31'd0, (!exp_valid || rr)});
    if (exp_valid) begin
      e = sb[0];
      checkOutput("rsp_pass_a", {31'd0, rsp_pass_a}, {31'd0, e.pass_a});
      checkOutput("rsp_pass_b", {31'd0, rsp_pass_b}, {31'd0, e.pass_b});
      checkOutput("rsp_undef_a", {31'd0, rsp_undef_a}, {31'd0, e.undef});
      checkOutput("rsp_undef_b", {31'd0, rsp_undef_b}, {31'd0, e.undef});
      checkOutput("rsp_tag_a", {28'd0, rsp_tag_a}, {28'd0, e.tag});
      checkOutput("rsp_tag_b", {28'd0, rsp_tag_b}, {28'd0, e.tag});
      if (rr) void'(sb.pop_front());
    end
    checkOutput("status_a", {28'd0, status_a}, {28'd0, m_status});
    checkOutput("status_b", {28'd0, status_b}, {28'd0, m_status});
    checkOutput("eval_count_a", {16'd0, eval_count_a}, {16'd0, m_cnt_a});
    checkOutput("eval_count_b", {30'd0, eval_count_b}, {30'd0, m_cnt_b});
    if (v && (!exp_valid || rr)) begin
      e.pass_a = modelPass(cond, we ? fl : m_status);
      e.pass_b = modelPass(cond, m_status);
      e.undef  = (cond == 4'hF);
      e.tag    = tag;
      sb.push_back(e);
      if (m_cnt_a != 16'hFFFF) m_cnt_a = m_cnt_a + 16'd1;
      if (m_cnt_b != 2'b11) m_cnt_b = m_cnt_b + 2'd1;
    end
    if (we) m_status = fl;
  endtask

  initial begin
    reset_n = 1'b0; flags_we = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    flags_in = 4'h0; req_cond = 4'h0; req_tag = 4'h0;

    $display("[TB] status write with EQ then NE");
    applyReset();
    applyStimulus(1'b1, 4'b0100, 1'b1, 4'h0, 4'h1, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1, 4'h1, 4'h2, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'h0, 4'h0, 1'b1);

    $display("[TB] same-cycle flag write forwarding");
    applyReset();
    applyStimulus(1'b1, 4'b1000, 1'b1, 4'h2, 4'h3, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'h0, 4'h0, 1'b1);

    $display("[TB] signed comparisons");
    applyStimulus(1'b1, 4'b0010, 1'b0, 4'h0, 4'h0, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1, 4'hA, 4'h1, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1, 4'hB, 4'h2, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1, 4'hC, 4'h3, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1, 4'hD, 4'h4, 1'b1);
    applyStimulus(1'b1, 4'b0011, 1'b0, 4'h0, 4'h0, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1, 4'hA, 4'h5, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1, 4'hC, 4'h6, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'h0, 4'h0, 1'b1);

    $display("[TB] response stall with flag write under it");
    applyStimulus(1'b0, 4'b0000, 1'b1, 4'h6, 4'h5, 1'b0);
    applyStimulus(1'b1, 4'b1100, 1'b1, 4'h0, 4'h7, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b1, 4'h0, 4'h8, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b1, 4'h0, 4'h9, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b1, 4'h0, 4'hA, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'h0, 4'h0, 1'b1);

    $display("[TB] NV and AL");
    applyStimulus(1'b0, 4'b0000, 1'b1, 4'hF, 4'hB, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'($urandom_range(0, 15)), 1'b1, 4'hE, 4'(i), 1'b1);
    end
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'h0, 4'h0, 1'b1);

    $display("[TB] randomised traffic");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] counter saturation and reset with pending response");
    applyReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'hE, 4'(i), 1'b1);
    end
    applyStimulus(1'b0, 4'b0000, 1'b1, 4'h0, 4'hC, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'h0, 4'h0, 1'b0);
    applyReset();
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'h0, 4'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
